tl_ul_uart: RTL

- TileLink-UL slave UART that sits on one switch output port, downstream of tl_switch, like tl_memory and tl_ul_bios.
- Converts CPU register accesses into 8N1 serial traffic on UART_TX/UART_RX.
- Buffers bytes in small TX and RX FIFOs.
- Drives uart_irq into the CPU's external interrupt input.

---
 rtl/tl_pkg.sv | 23 ++
 rtl/tl_uart_fifo.sv | 51 +++++
 rtl/tl_ul_uart.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink-UL opcode constants, UART register map and serial FSM state type.
package tl_pkg;

  localparam logic [2:0] A_PUT_FULL        = 3'd0;
  localparam logic [2:0] A_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] A_GET             = 3'd4;
  localparam logic [2:0] D_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;

  localparam logic [7:0] REG_TXDATA = 8'h00;
  localparam logic [7:0] REG_RXDATA = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h08;
  localparam logic [7:0] REG_CTRL   = 8'h0C;
  localparam logic [7:0] REG_DIV    = 8'h10;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_st_e;

  // Bit periods shorter than 4 clocks leave no room for the mid-bit sample.
  function automatic logic [15:0] clamp_div(input logic [15:0] v);
    return (v < 16'd4) ? 16'd4 : v;
  endfunction

endpackage

// File: rtl/tl_uart_fifo.sv
// Small first-word-fall-through FIFO; a pop frees a slot for a push in the same cycle.
module tl_uart_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_FULL);
  assign empty     = (r_count == '0);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd_ptr];

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/tl_ul_uart.sv
// TileLink-UL slave UART: register decode, single-outstanding D channel, 8N1 TX/RX engines.
module tl_ul_uart
  import tl_pkg::*;
#(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned SID_WIDTH   = 8,
  parameter int unsigned CLK_FREQ_HZ = 27000000,
  parameter int unsigned BAUD_RATE   = 115200,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tl_a_valid,
  output logic                 tl_a_ready,
  input  logic [2:0]           tl_a_opcode,
  input  logic [2:0]           tl_a_param,
  input  logic [2:0]           tl_a_size,
  input  logic [SID_WIDTH-1:0] tl_a_source,
  input  logic [XLEN-1:0]      tl_a_address,
  input  logic [XLEN/8-1:0]    tl_a_mask,
  input  logic [XLEN-1:0]      tl_a_data,
  output logic                 tl_d_valid,
  input  logic                 tl_d_ready,
  output logic [2:0]           tl_d_opcode,
  output logic [1:0]           tl_d_param,
  output logic [2:0]           tl_d_size,
  output logic [SID_WIDTH-1:0] tl_d_source,
  output logic [XLEN-1:0]      tl_d_data,
  output logic                 tl_d_corrupt,
  output logic                 tl_d_denied,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  output logic                 irq
);

  localparam logic [15:0] DIV_RST = 16'(CLK_FREQ_HZ / BAUD_RATE);

  logic                 r_d_valid, r_d_denied, r_irq;
  logic [2:0]           r_d_opcode, r_d_size;
  logic [SID_WIDTH-1:0] r_d_source;
  logic [XLEN-1:0]      r_d_data;
  logic [1:0]           r_ctrl;
  logic [15:0]          r_div;
  logic                 r_tx_ovf, r_rx_ovr, r_frame_err;
  logic                 r_rx_meta, r_rx_sync;

  logic       w_a_fire, w_err, w_is_get, w_is_put, w_wr, w_rd;
  logic [7:0] w_offset, w_status;
  logic [31:0] w_rdata;
  logic [15:0] w_div_wdata;
  logic       w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_drop, w_tx_busy;
  logic       w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_drop, w_rx_ferr;
  logic [7:0] w_tx_dout, w_rx_dout;
  logic       w_unused_bits;

  assign w_unused_bits = ^{tl_a_param, tl_a_address[XLEN-1:8], tl_a_data[XLEN-1:16],
                           tl_a_mask[XLEN/8-1:2]};

  // ---------------- bus decode ----------------
  assign tl_a_ready = !r_d_valid;
  assign w_a_fire   = tl_a_valid && tl_a_ready;
  assign w_offset   = tl_a_address[7:0];
  assign w_is_get   = (tl_a_opcode == A_GET);
  assign w_is_put   = (tl_a_opcode == A_PUT_FULL) || (tl_a_opcode == A_PUT_PARTIAL);
  assign w_err      = (tl_a_address[1:0] != 2'b00) || (tl_a_size > 3'd2) ||
                      (w_offset > REG_DIV) || !(w_is_get || w_is_put);
  assign w_wr       = w_a_fire && !w_err && w_is_put;
  assign w_rd       = w_a_fire && !w_err && w_is_get;

  assign w_tx_push   = w_wr && (w_offset == REG_TXDATA) && tl_a_mask[0];
  assign w_rx_pop    = w_rd && (w_offset == REG_RXDATA);
  assign w_tx_drop   = w_tx_push && w_tx_full && !w_tx_pop;
  assign w_rx_drop   = w_rx_push && w_rx_full && !w_rx_pop;
  assign w_div_wdata = {tl_a_mask[1] ? tl_a_data[15:8] : r_div[15:8],
                        tl_a_mask[0] ? tl_a_data[7:0]  : r_div[7:0]};
  assign w_status    = {r_tx_ovf, r_frame_err, r_rx_ovr, w_tx_busy,
                        w_rx_full, w_rx_empty, w_tx_full, w_tx_empty};

  // Read data mux; RXDATA returns byte 0 when empty.
  always_comb begin
    w_rdata = '0;
    case (w_offset)
      REG_TXDATA: w_rdata[31] = w_tx_full;
      REG_RXDATA: begin
        w_rdata[31]  = w_rx_empty;
        w_rdata[7:0] = w_rx_empty ? 8'h00 : w_rx_dout;
      end
      REG_STATUS: w_rdata[7:0]  = w_status;
      REG_CTRL:   w_rdata[1:0]  = r_ctrl;
      REG_DIV:    w_rdata[15:0] = r_div;
      default:    w_rdata = '0;
    endcase
  end

  // D channel response register, held until accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_d_valid  <= 1'b0;
      r_d_opcode <= '0;
      r_d_size   <= '0;
      r_d_source <= '0;
      r_d_data   <= '0;
      r_d_denied <= 1'b0;
    end else if (w_a_fire) begin
      r_d_valid  <= 1'b1;
      r_d_opcode <= w_is_get ? D_ACCESS_ACK_DATA : D_ACCESS_ACK;
      r_d_size   <= tl_a_size;
      r_d_source <= tl_a_source;
      r_d_data   <= w_rd ? XLEN'(w_rdata) : '0;
      r_d_denied <= w_err;
    end else if (r_d_valid && tl_d_ready) begin
      r_d_valid  <= 1'b0;
    end
  end

  assign tl_d_valid   = r_d_valid;
  assign tl_d_opcode  = r_d_opcode;
  assign tl_d_param   = 2'b00;
  assign tl_d_size    = r_d_size;
  assign tl_d_source  = r_d_source;
  assign tl_d_data    = r_d_data;
  assign tl_d_corrupt = 1'b0;
  assign tl_d_denied  = r_d_denied;
  assign irq          = r_irq;

  // Control registers and sticky errors; a new error wins over a same-cycle clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ctrl      <= '0;
      r_div       <= DIV_RST;
      r_tx_ovf    <= 1'b0;
      r_rx_ovr    <= 1'b0;
      r_frame_err <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      if (w_wr && (w_offset == REG_CTRL) && tl_a_mask[0]) r_ctrl <= tl_a_data[1:0];
      if (w_wr && (w_offset == REG_DIV) && |tl_a_mask[1:0]) r_div <= clamp_div(w_div_wdata);
      if (w_wr && (w_offset == REG_STATUS) && tl_a_mask[0]) begin
        if (tl_a_data[5]) r_rx_ovr    <= 1'b0;
        if (tl_a_data[6]) r_frame_err <= 1'b0;
        if (tl_a_data[7]) r_tx_ovf    <= 1'b0;
      end
      if (w_tx_drop) r_tx_ovf    <= 1'b1;
      if (w_rx_drop) r_rx_ovr    <= 1'b1;
      if (w_rx_ferr) r_frame_err <= 1'b1;
      r_irq <= (r_ctrl[0] && !w_rx_empty) || (r_ctrl[1] && w_tx_empty);
    end
  end

  tl_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_tx_push),
    .pop   (w_tx_pop),
    .din   (tl_a_data[7:0]),
    .dout  (w_tx_dout),
    .full  (w_tx_full),
    .empty (w_tx_empty)
  );

  // ---------------- TX engine ----------------
  uart_st_e    r_tx_st, w_tx_st_d;
  logic [15:0] r_tx_cnt, w_tx_cnt_d, r_tx_div, w_tx_div_d;
  logic [2:0]  r_tx_bit, w_tx_bit_d;
  logic [7:0]  r_tx_shift, w_tx_shift_d;
  logic        r_tx_out, w_tx_out_d, w_tx_bit_end;

  assign w_tx_bit_end = (r_tx_cnt == r_tx_div - 16'd1);
  assign w_tx_busy    = (r_tx_st != StIdle);
  assign uart_tx      = r_tx_out;

  // TX next state; the line level is registered from the next state to stay glitch-free.
  always_comb begin
    w_tx_st_d    = r_tx_st;
    w_tx_cnt_d   = r_tx_cnt + 16'd1;
    w_tx_bit_d   = r_tx_bit;
    w_tx_shift_d = r_tx_shift;
    w_tx_div_d   = r_tx_div;
    w_tx_pop     = 1'b0;
    unique case (r_tx_st)
      StIdle: begin
        w_tx_cnt_d = '0;
        if (!w_tx_empty) begin
          w_tx_pop     = 1'b1;
          w_tx_shift_d = w_tx_dout;
          w_tx_div_d   = r_div;
          w_tx_st_d    = StStart;
        end
      end
      StStart: if (w_tx_bit_end) begin
        w_tx_cnt_d = '0;
        w_tx_bit_d = '0;
        w_tx_st_d  = StData;
      end
      StData: if (w_tx_bit_end) begin
        w_tx_cnt_d   = '0;
        w_tx_shift_d = r_tx_shift >> 1;
        w_tx_bit_d   = r_tx_bit + 3'd1;
        if (r_tx_bit == 3'd7) w_tx_st_d = StStop;
      end
      StStop: if (w_tx_bit_end) begin
        w_tx_cnt_d = '0;
        if (!w_tx_empty) begin
          w_tx_pop     = 1'b1;
          w_tx_shift_d = w_tx_dout;
          w_tx_div_d   = r_div;
          w_tx_st_d    = StStart;
        end else begin
          w_tx_st_d = StIdle;
        end
      end
      default: w_tx_st_d = StIdle;
    endcase
    w_tx_out_d = 1'b1;
    if (w_tx_st_d == StStart)     w_tx_out_d = 1'b0;
    else if (w_tx_st_d == StData) w_tx_out_d = w_tx_shift_d[0];
  end

  // TX state register; reset forces the line idle-high immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tx_st    <= StIdle;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_div   <= DIV_RST;
      r_tx_out   <= 1'b1;
    end else begin
      r_tx_st    <= w_tx_st_d;
      r_tx_cnt   <= w_tx_cnt_d;
      r_tx_bit   <= w_tx_bit_d;
      r_tx_shift <= w_tx_shift_d;
      r_tx_div   <= w_tx_div_d;
      r_tx_out   <= w_tx_out_d;
    end
  end

  // ---------------- RX engine ----------------
  uart_st_e    r_rx_st, w_rx_st_d;
  logic [15:0] r_rx_cnt, w_rx_cnt_d, r_rx_div, w_rx_div_d;
  logic [2:0]  r_rx_bit, w_rx_bit_d;
  logic [7:0]  r_rx_shift, w_rx_shift_d;
  logic        w_rx_bit_end;

  assign w_rx_bit_end = (r_rx_cnt == r_rx_div - 16'd1);

  // RX next state: confirm start at half a bit, then sample each bit centre.
  always_comb begin
    w_rx_st_d    = r_rx_st;
    w_rx_cnt_d   = r_rx_cnt + 16'd1;
    w_rx_bit_d   = r_rx_bit;
    w_rx_shift_d = r_rx_shift;
    w_rx_div_d   = r_rx_div;
    w_rx_push    = 1'b0;
    w_rx_ferr    = 1'b0;
    unique case (r_rx_st)
      StIdle: begin
        w_rx_cnt_d = '0;
        if (!r_rx_sync) begin
          w_rx_div_d = r_div;
          w_rx_st_d  = StStart;
        end
      end
      StStart: if (r_rx_cnt == (r_rx_div >> 1) - 16'd1) begin
        w_rx_cnt_d = '0;
        w_rx_bit_d = '0;
        w_rx_st_d  = r_rx_sync ? StIdle : StData;
      end
      StData: if (w_rx_bit_end) begin
        w_rx_cnt_d   = '0;
        w_rx_shift_d = {r_rx_sync, r_rx_shift[7:1]};
        w_rx_bit_d   = r_rx_bit + 3'd1;
        if (r_rx_bit == 3'd7) w_rx_st_d = StStop;
      end
      StStop: if (w_rx_bit_end) begin
        w_rx_cnt_d = '0;
        w_rx_push  = r_rx_sync;
        w_rx_ferr  = !r_rx_sync;
        w_rx_st_d  = StIdle;
      end
      default: w_rx_st_d = StIdle;
    endcase
  end

  // RX synchroniser and state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rx_meta  <= 1'b1;
      r_rx_sync  <= 1'b1;
      r_rx_st    <= StIdle;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_div   <= DIV_RST;
    end else begin
      r_rx_meta  <= uart_rx;
      r_rx_sync  <= r_rx_meta;
      r_rx_st    <= w_rx_st_d;
      r_rx_cnt   <= w_rx_cnt_d;
      r_rx_bit   <= w_rx_bit_d;
      r_rx_shift <= w_rx_shift_d;
      r_rx_div   <= w_rx_div_d;
    end
  end

  tl_uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_rx_push),
    .pop   (w_rx_pop),
    .din   (w_rx_shift_d),
    .dout  (w_rx_dout),
    .full  (w_rx_full),
    .empty (w_rx_empty)
  );

endmodule
